// File: rtl/game_pkg.sv
// game_pkg
// Shared types and constants for the game-side session controller.
//   game_state_t : session FSM states (IDLE, ARM, PLAY, LIFE_LOST, FINISH)
//   SCORE_MAX    : value at which the score counter saturates
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    PLAY,
    LIFE_LOST,
    FINISH
  } game_state_t;

  localparam logic [7:0] SCORE_MAX = 8'd255;

endpackage

// File: rtl/life_timer.sv
// life_timer
// Per-life countdown. Reloads to PLAY_CYCLES-1 and counts down to zero,
// where it sticks until the next reload.
// Ports:
//   clk     in  : system clock
//   rst_n   in  : synchronous active-low reset, clears the count
//   load    in  : reload count to PLAY_CYCLES-1 (wins over en)
//   en      in  : decrement by one, saturating at zero
//   count   out : current remaining cycles (registered)
//   expired out : combinational, high while count is zero
module life_timer #(
  parameter int PLAY_CYCLES = 200
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           load,
  input  logic                           en,
  output logic [$clog2(PLAY_CYCLES)-1:0] count,
  output logic                           expired
);

  localparam int CW = $clog2(PLAY_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(PLAY_CYCLES - 1);

  logic [CW-1:0] count_q;

  // Countdown register; holding at zero keeps the value from wrapping
  // while the FSM is still deciding what the timeout costs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= RELOAD;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - CW'(1);
    end
  end

  assign count   = count_q;
  assign expired = (count_q == '0);

endmodule

// File: rtl/game_session.sv
// game_session
// Runs one paid game per qualified start from the coin casher: per-life
// countdown, life counter, saturating score, and a one-cycle finish pulse
// back to the casher.
// Ports:
//   clk          in  : system clock
//   power        in  : synchronous active-low reset
//   game_start   in  : start pulse from the casher
//   eat_coins    in  : casher consumed the coins (qualifies game_start)
//   player_hit   in  : lose-a-life pulse
//   player_quit  in  : abandon-game pulse
//   bonus        in  : score pulse
//   game_finish  out : one-cycle session-over pulse
//   playing      out : high in PLAY and LIFE_LOST
//   lives_left   out : remaining lives
//   time_left    out : remaining cycles in the current life
//   score        out : saturating score
module game_session
  import game_pkg::*;
#(
  parameter int PLAY_CYCLES = 200,
  parameter int LIVES       = 3
) (
  input  logic                           clk,
  input  logic                           power,
  input  logic                           game_start,
  input  logic                           eat_coins,
  input  logic                           player_hit,
  input  logic                           player_quit,
  input  logic                           bonus,
  output logic                           game_finish,
  output logic                           playing,
  output logic [2:0]                     lives_left,
  output logic [$clog2(PLAY_CYCLES)-1:0] time_left,
  output logic [7:0]                     score
);

  game_state_t state_q, state_d;
  logic [2:0]  lives_q, lives_d;
  logic [7:0]  score_q, score_d;
  logic        finish_q, playing_q;
  logic        timerLoad, timerEn, timerExpired;

  life_timer #(
    .PLAY_CYCLES(PLAY_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (power),
    .load   (timerLoad),
    .en     (timerEn),
    .count  (time_left),
    .expired(timerExpired)
  );

  // Next-state, lives and score logic. The timer reloads while sitting in
  // ARM or LIFE_LOST, so each PLAY stretch starts at PLAY_CYCLES-1.
  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    score_d   = score_q;
    timerLoad = (state_q == ARM) || (state_q == LIFE_LOST);
    timerEn   = (state_q == PLAY);

    // Bonus counts in PLAY and LIFE_LOST, including hit/quit cycles.
    if (((state_q == PLAY) || (state_q == LIFE_LOST)) && bonus &&
        (score_q != SCORE_MAX)) begin
      score_d = score_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (game_start && eat_coins) state_d = ARM;
      end
      ARM: begin
        lives_d = 3'(LIVES);
        score_d = '0;
        state_d = PLAY;
      end
      PLAY: begin
        // Quit wins and keeps the lives count; hit and timeout together
        // still cost only one life.
        if (player_quit) begin
          state_d = FINISH;
        end else if (player_hit || timerExpired) begin
          lives_d = lives_q - 3'd1;
          state_d = (lives_q == 3'd1) ? FINISH : LIFE_LOST;
        end
      end
      LIFE_LOST: state_d = PLAY;
      FINISH:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // State and output registers. Status outputs are registered from the
  // next state so they line up with state_q without extra decode.
  always_ff @(posedge clk) begin
    if (!power) begin
      state_q   <= IDLE;
      lives_q   <= '0;
      score_q   <= '0;
      finish_q  <= 1'b0;
      playing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      score_q   <= score_d;
      finish_q  <= (state_d == FINISH);
      playing_q <= (state_d == PLAY) || (state_d == LIFE_LOST);
    end
  end

  assign game_finish = finish_q;
  assign playing     = playing_q;
  assign lives_left  = lives_q;
  assign score       = score_q;

endmodule

// File: tb/tb_game_session.sv
// tb_game_session
// Directed bench for game_session with PLAY_CYCLES=8, LIVES=3, plus a
// second instance with a long life used to reach score saturation.
module tb_game_session;
  import game_pkg::*;

  logic       clk;
  logic       power;
  logic       game_start, eat_coins, player_hit, player_quit, bonus;
  logic       game_finish, playing;
  logic [2:0] lives_left;
  logic [2:0] time_left;
  logic [7:0] score;

  logic       start2, coins2, bonus2, zero2;
  logic       finish2, playing2;
  logic [2:0] lives2;
  logic [8:0] time2;
  logic [7:0] score2;

  int nChecks = 0;
  int nFails  = 0;
  int cyc;

  game_session #(.PLAY_CYCLES(8), .LIVES(3)) dut (
    .clk        (clk),
    .power      (power),
    .game_start (game_start),
    .eat_coins  (eat_coins),
    .player_hit (player_hit),
    .player_quit(player_quit),
    .bonus      (bonus),
    .game_finish(game_finish),
    .playing    (playing),
    .lives_left (lives_left),
    .time_left  (time_left),
    .score      (score)
  );

  game_session #(.PLAY_CYCLES(300), .LIVES(1)) dut2 (
    .clk        (clk),
    .power      (power),
    .game_start (start2),
    .eat_coins  (coins2),
    .player_hit (zero2),
    .player_quit(zero2),
    .bonus      (bonus2),
    .game_finish(finish2),
    .playing    (playing2),
    .lives_left (lives2),
    .time_left  (time2),
    .score      (score2)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a one-cycle pulse pattern to the main DUT, then clear it.
  task automatic applyStimulus(input logic start, input logic coins,
                               input logic hit, input logic quit,
                               input logic bon);
    game_start  = start;
    eat_coins   = coins;
    player_hit  = hit;
    player_quit = quit;
    bonus       = bon;
    tick();
    game_start  = 1'b0;
    eat_coins   = 1'b0;
    player_hit  = 1'b0;
    player_quit = 1'b0;
    bonus       = 1'b0;
  endtask

  // One comparison: counted, asserted, reported on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Directed sequence; expected values are hand-computed for 8 cycles/life.
  initial begin
    power = 1'b0;
    game_start = 1'b0; eat_coins = 1'b0; player_hit = 1'b0;
    player_quit = 1'b0; bonus = 1'b0;
    start2 = 1'b0; coins2 = 1'b0; bonus2 = 1'b0; zero2 = 1'b0;

    // Reset held for three edges
    repeat (3) tick();
    checkOutput("rst_finish", 32'(game_finish), 32'd0);
    checkOutput("rst_playing", 32'(playing), 32'd0);
    checkOutput("rst_lives", 32'(lives_left), 32'd0);
    checkOutput("rst_time", 32'(time_left), 32'd0);
    checkOutput("rst_score", 32'(score), 32'd0);
    checkOutput("rst_state", 32'(dut.state_q), 32'(IDLE));
    power = 1'b1;
    tick();

    // Start without coins is ignored
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("nocoin_state", 32'(dut.state_q), 32'(IDLE));
    checkOutput("nocoin_playing", 32'(playing), 32'd0);

    // Normal start: ARM then PLAY with full lives and time
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("arm_playing", 32'(playing), 32'd0);
    checkOutput("arm_state", 32'(dut.state_q), 32'(ARM));
    tick();
    checkOutput("play_playing", 32'(playing), 32'd1);
    checkOutput("play_lives", 32'(lives_left), 32'd3);
    checkOutput("play_time", 32'(time_left), 32'd7);
    checkOutput("play_score", 32'(score), 32'd0);

    // Life 1 times out after 8 PLAY cycles
    repeat (7) tick();
    checkOutput("life1_time0", 32'(time_left), 32'd0);
    checkOutput("life1_lives", 32'(lives_left), 32'd3);
    tick();
    checkOutput("lost1_state", 32'(dut.state_q), 32'(LIFE_LOST));
    checkOutput("lost1_lives", 32'(lives_left), 32'd2);
    checkOutput("lost1_playing", 32'(playing), 32'd1);
    tick();
    checkOutput("life2_time", 32'(time_left), 32'd7);

    // Remaining 17 cycles to the finish pulse (26 after PLAY entry)
    cyc = 0;
    while ((game_finish !== 1'b1) && (cyc < 40)) begin
      tick();
      cyc++;
    end
    checkOutput("timeout_cycles", 32'(cyc), 32'd17);
    checkOutput("timeout_lives", 32'(lives_left), 32'd0);
    checkOutput("timeout_playing", 32'(playing), 32'd0);
    tick();
    checkOutput("timeout_pulse_end", 32'(game_finish), 32'd0);
    checkOutput("timeout_idle", 32'(dut.state_q), 32'(IDLE));
    checkOutput("timeout_lives_hold", 32'(lives_left), 32'd0);

    // Hit at time_left=5
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    repeat (2) tick();
    checkOutput("hit_pre_time", 32'(time_left), 32'd5);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("hit_state", 32'(dut.state_q), 32'(LIFE_LOST));
    checkOutput("hit_lives", 32'(lives_left), 32'd2);
    tick();
    checkOutput("hit_reload", 32'(time_left), 32'd7);
    checkOutput("hit_replay", 32'(dut.state_q), 32'(PLAY));

    // Hit coinciding with timeout costs one life
    repeat (7) tick();
    checkOutput("hitto_time0", 32'(time_left), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("hitto_lives", 32'(lives_left), 32'd1);
    checkOutput("hitto_state", 32'(dut.state_q), 32'(LIFE_LOST));
    tick();

    // Three bonus pulses, then quit+hit+bonus on the last life
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("bonus3_score", 32'(score), 32'd3);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("quit_finish", 32'(game_finish), 32'd1);
    checkOutput("quit_playing", 32'(playing), 32'd0);
    checkOutput("quit_lives", 32'(lives_left), 32'd1);
    checkOutput("quit_score", 32'(score), 32'd4);
    checkOutput("quit_time", 32'(time_left), 32'd3);
    tick();
    checkOutput("quit_pulse_end", 32'(game_finish), 32'd0);
    checkOutput("quit_score_hold", 32'(score), 32'd4);

    // Bonus in IDLE is ignored
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("idle_bonus", 32'(score), 32'd4);

    // Next start clears score
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("restart_score", 32'(score), 32'd0);
    checkOutput("restart_lives", 32'(lives_left), 32'd3);

    // Start during PLAY is ignored
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("midstart_state", 32'(dut.state_q), 32'(PLAY));
    checkOutput("midstart_time", 32'(time_left), 32'd6);

    // Mid-game reset aborts without a finish pulse
    power = 1'b0;
    tick();
    checkOutput("midrst_state", 32'(dut.state_q), 32'(IDLE));
    checkOutput("midrst_finish", 32'(game_finish), 32'd0);
    checkOutput("midrst_playing", 32'(playing), 32'd0);
    checkOutput("midrst_lives", 32'(lives_left), 32'd0);
    checkOutput("midrst_time", 32'(time_left), 32'd0);
    power = 1'b1;
    tick();
    checkOutput("midrst_nofinish", 32'(game_finish), 32'd0);

    // Score saturation on the long-life instance
    start2 = 1'b1; coins2 = 1'b1;
    tick();
    start2 = 1'b0; coins2 = 1'b0;
    tick();
    checkOutput("sat_time_start", 32'(time2), 32'd299);
    bonus2 = 1'b1;
    repeat (254) tick();
    checkOutput("sat_score254", 32'(score2), 32'd254);
    repeat (3) tick();
    bonus2 = 1'b0;
    checkOutput("sat_score255", 32'(score2), 32'd255);
    checkOutput("sat_time", 32'(time2), 32'd42);
    checkOutput("sat_playing", 32'(playing2), 32'd1);
    checkOutput("sat_lives", 32'(lives2), 32'd1);
    checkOutput("sat_finish", 32'(finish2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/game_session.md
# game_session

Game-side session controller at the far end of the coin casher's start/finish handshake. Accepts the casher's one-cycle `game_start` (qualified by `eat_coins`) and runs one paid game: a per-life countdown, a life counter and a saturating score. It returns the one-cycle `game_finish` pulse that releases the casher from its wait-for-finish state.

## Interface
- `PLAY_CYCLES`, default 200: cycles allowed per life before a timeout costs a life; legal range ≥2.
- `LIVES`, default 3: lives per paid game; legal range 1..7.
- `clk`  in  1: system clock, all logic on rising edge.
- `power`  in  1: reset; synchronous, active-low (power=0 holds the block in reset).
- `game_start`  in  1: start request from the casher, one-cycle pulse.
- `eat_coins`  in  1: casher has consumed the coins; must be high in the same cycle as `game_start`.
- `player_hit`  in  1: player lost a life, one-cycle pulse.
- `player_quit`  in  1: player abandons the game, one-cycle pulse.
- `bonus`  in  1: score event, one-cycle pulse.
- `game_finish`  out  1: session over; one-cycle pulse to the casher.
- `playing`  out  1: high in PLAY and LIFE_LOST.
- `lives_left`  out  3: remaining lives.
- `time_left`  out  $clog2(PLAY_CYCLES): remaining cycles in the current life.
- `score`  out  8: saturating score, held after finish until the next start.

## Operation
- States: IDLE, ARM, PLAY, LIFE_LOST, FINISH.
- IDLE: leaves for ARM only when `game_start & eat_coins`. `game_start` without `eat_coins` is ignored, and the block stays in IDLE.
- ARM, one cycle: `lives_left`=LIVES, `time_left`=PLAY_CYCLES-1, `score`=0. Next state is PLAY.
- PLAY: `time_left` decrements each cycle. A life is lost on `player_hit`, or on timeout when `time_left`==0.
  - Simultaneous hit and timeout costs exactly one life.
  - On a lost life, `lives_left` decrements. If the result is 0, go to FINISH; otherwise go to LIFE_LOST.
  - `player_quit` goes to FINISH. Quit has priority over hit and timeout, and `lives_left` is not decremented.
- LIFE_LOST, one cycle: reloads `time_left`=PLAY_CYCLES-1. `player_hit` and `player_quit` are ignored in this state. Next state is PLAY.
- FINISH, one cycle: `game_finish`=1. Next state is IDLE.
- `bonus`: `score`+1, saturating at 255. Counted in PLAY and LIFE_LOST, including the cycle of a hit or quit; ignored in IDLE, ARM and FINISH.
- `game_start` outside IDLE is ignored; the casher never re-arms mid-game.

## Timing
- Reset (`power`=0 at a clock edge) forces IDLE. All outputs become 0: `game_finish`, `playing`, `lives_left`, `time_left`, `score`.
- Reset applied mid-game aborts it with no `game_finish` pulse.
- All outputs are registered. `game_start` at edge N puts ARM at N+1 and PLAY (`playing`=1) at N+2.
- Timeout: with no hits, life 1 ends PLAY_CYCLES cycles after PLAY is entered. Each later life gets PLAY_CYCLES PLAY cycles after its LIFE_LOST cycle.
- `game_finish` is high for exactly one cycle, the cycle after the terminating event. `playing` is 0 in that cycle.
- `lives_left` and `time_left` hold their final values through FINISH and IDLE until the next ARM.
- `time_left` never wraps below 0; reload occurs only in ARM and LIFE_LOST.

## Structure
- Package `game_pkg`: `game_state_t` enum (IDLE, ARM, PLAY, LIFE_LOST, FINISH) and `SCORE_MAX`=8'd255.
- Sub-module `life_timer`, parameterised by PLAY_CYCLES. Inputs: `load`, `en`. Outputs: `count` and a combinational `expired`=(count==0).
- `game_session` holds the FSM, the lives counter and the score counter.

## Test plan
All scenarios use PLAY_CYCLES=8, LIVES=3.
- Reset: hold `power`=0 for 3 cycles → all outputs 0, state IDLE. Pulse `game_start` with `eat_coins`=0 → stays IDLE, `playing`=0.
- Normal start plus full timeout: pulse `game_start`+`eat_coins` → `playing` high 2 cycles later, `lives_left`=3, `time_left`=7.
  - With no input, `lives_left` steps 3→2→1→0.
  - One `game_finish` pulse occurs 26 cycles after PLAY entry: 3 lives × 8 PLAY cycles, plus the LIFE_LOST cycle after each of the first two lives.
- Hit during play: `player_hit` when `time_left`=5 → `lives_left` 3→2, one LIFE_LOST cycle, then `time_left`=7. Hit together with timeout → only one life lost.
- Quit priority: `player_quit`+`player_hit` in the same PLAY cycle → `game_finish` next cycle, `lives_left` unchanged, `score` retained.
- Score: 3 `bonus` pulses in PLAY → `score`=3. Preloaded `score`=254 plus 3 bonus pulses → 255. `bonus` in IDLE → no change. The next start clears `score` to 0.
- Mid-game reset: `power`=0 during PLAY → IDLE next edge, outputs 0, no `game_finish`. `game_start` during PLAY → ignored.
